// File: rtl/ble_usb_framer.sv
// ble_usb_framer
// Deserialises one BLE packet from the sniffer front-end, buffers its bytes
// and then emits a single USB frame: RSSI, channel, {trunc, length}, payload.
// Backpressure comes from ready_i; bad or overlapping packets pulse drop_o.
module ble_usb_framer #(
    parameter int unsigned DATA_O_SIZE        = 8,
    parameter int unsigned CHANNEL_FIELD_SIZE = 7,
    parameter int unsigned RSSI_FIELD_SIZE    = 8,
    parameter int unsigned MAX_BYTES          = 64,
    parameter int unsigned CHANNEL_MAX        = 39,
    parameter bit          LSB_FIRST          = 1'b1
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          serial_i,
    input  logic                          valid_i,
    input  logic [CHANNEL_FIELD_SIZE-1:0] channel_i,
    input  logic [RSSI_FIELD_SIZE-1:0]    rssi_i,
    input  logic                          ready_i,
    output logic [DATA_O_SIZE-1:0]        data_o,
    output logic                          valid_o,
    output logic                          frame_o,
    output logic                          busy_o,
    output logic                          drop_o
);

    localparam int unsigned BIDX_W = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam logic [6:0]  MAX_CNT = 7'(MAX_BYTES);
    localparam logic [CHANNEL_FIELD_SIZE-1:0] CH_MAX = CHANNEL_FIELD_SIZE'(CHANNEL_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RX,
        S_FLUSH,
        S_EMIT
    } state_t;

    state_t                        state_q;
    state_t                        state_d;

    logic [7:0]                    sr_q;
    logic [2:0]                    bit_cnt_q;
    logic [6:0]                    count_q;
    logic                          trunc_q;
    logic [RSSI_FIELD_SIZE-1:0]    rssi_q;
    logic [CHANNEL_FIELD_SIZE-1:0] ch_q;
    logic [7:0]                    len_q;
    logic [7:0]                    beat_q;
    logic                          ignore_q;
    logic                          drop_q;
    logic [7:0]                    buffer_q [MAX_BYTES];

    logic [7:0]                    sr_next;
    logic [7:0]                    first_bits;
    logic                          full;
    logic                          pkt_bad;
    logic                          new_burst;
    logic                          last_beat;
    logic [BIDX_W-1:0]             rd_idx;
    logic [BIDX_W-1:0]             wr_idx;

    // Shift-register update and per-cycle qualifiers shared by FSM and datapath
    always_comb begin
        sr_next    = LSB_FIRST ? {serial_i, sr_q[7:1]} : {sr_q[6:0], serial_i};
        first_bits = LSB_FIRST ? {serial_i, 7'b0} : {7'b0, serial_i};
        full       = (count_q == MAX_CNT);
        pkt_bad    = (count_q == 7'd0) || (ch_q > CH_MAX);
        // ignore_q masks the remainder of a burst that began while framing
        new_burst  = valid_i && !ignore_q;
        last_beat  = (beat_q == ({1'b0, count_q} + 8'd2));
        rd_idx     = BIDX_W'(beat_q - 8'd3);
        wr_idx     = BIDX_W'(count_q);
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (new_burst) begin
                    state_d = S_RX;
                end
            end
            S_RX: begin
                if (!valid_i) begin
                    state_d = pkt_bad ? S_IDLE : S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_d = S_EMIT;
            end
            S_EMIT: begin
                if (ready_i && last_beat) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Packet capture, buffer writes, header latch, beat counter and drop pulse
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sr_q      <= '0;
            bit_cnt_q <= '0;
            count_q   <= '0;
            trunc_q   <= 1'b0;
            rssi_q    <= '0;
            ch_q      <= '0;
            len_q     <= '0;
            beat_q    <= '0;
            ignore_q  <= 1'b0;
            drop_q    <= 1'b0;
            for (int unsigned i = 0; i < MAX_BYTES; i++) begin
                buffer_q[i] <= '0;
            end
        end else begin
            drop_q <= 1'b0;
            if (!valid_i) begin
                ignore_q <= 1'b0;
            end
            unique case (state_q)
                S_IDLE: begin
                    if (new_burst) begin
                        rssi_q    <= rssi_i;
                        ch_q      <= channel_i;
                        sr_q      <= first_bits;
                        bit_cnt_q <= 3'd1;
                        count_q   <= '0;
                        trunc_q   <= 1'b0;
                    end
                end
                S_RX: begin
                    if (valid_i) begin
                        if (full) begin
                            trunc_q <= 1'b1;
                        end else begin
                            sr_q      <= sr_next;
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                buffer_q[wr_idx] <= sr_next;
                                count_q          <= count_q + 7'd1;
                            end
                        end
                    end else if (pkt_bad) begin
                        drop_q <= 1'b1;
                    end
                end
                S_FLUSH: begin
                    len_q  <= {trunc_q, count_q};
                    beat_q <= '0;
                    if (new_burst) begin
                        drop_q   <= 1'b1;
                        ignore_q <= 1'b1;
                    end
                end
                S_EMIT: begin
                    if (ready_i) begin
                        beat_q <= beat_q + 8'd1;
                    end
                    if (new_burst) begin
                        drop_q   <= 1'b1;
                        ignore_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Output decode: beat index selects header field or buffered payload byte
    always_comb begin
        data_o  = '0;
        valid_o = 1'b0;
        frame_o = 1'b0;
        busy_o  = (state_q != S_IDLE);
        drop_o  = drop_q;
        if (state_q == S_EMIT) begin
            valid_o = 1'b1;
            frame_o = 1'b1;
            if (beat_q == 8'd0) begin
                data_o[RSSI_FIELD_SIZE-1:0] = rssi_q;
            end else if (beat_q == 8'd1) begin
                data_o[CHANNEL_FIELD_SIZE-1:0] = ch_q;
            end else if (beat_q == 8'd2) begin
                data_o[7:0] = len_q;
            end else begin
                data_o[7:0] = buffer_q[rd_idx];
            end
        end
    end

endmodule

// File: tb/tb_ble_usb_framer.sv
// tb_ble_usb_framer
// Directed bench for ble_usb_framer with default parameters: normal frame,
// backpressure, truncation, drops, overlapping burst and asynchronous reset.
module tb_ble_usb_framer;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       serial_i;
    logic       valid_i;
    logic [6:0] channel_i;
    logic [7:0] rssi_i;
    logic       ready_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       frame_o;
    logic       busy_o;
    logic       drop_o;

    ble_usb_framer #(
        .DATA_O_SIZE       (8),
        .CHANNEL_FIELD_SIZE(7),
        .RSSI_FIELD_SIZE   (8),
        .MAX_BYTES         (64),
        .CHANNEL_MAX       (39),
        .LSB_FIRST         (1'b1)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .serial_i (serial_i),
        .valid_i  (valid_i),
        .channel_i(channel_i),
        .rssi_i   (rssi_i),
        .ready_i  (ready_i),
        .data_o   (data_o),
        .valid_o  (valid_o),
        .frame_o  (frame_o),
        .busy_o   (busy_o),
        .drop_o   (drop_o)
    );

    always #5 clk_i = ~clk_i;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    int         fall_cyc;
    int         first_vo_cyc;
    int         frame_cycles;
    int         drop_cnt;
    int         rdy_phase;
    bit         rdy_toggle;
    bit         hold_pending;
    logic [7:0] held;
    logic [7:0] got_q [$];
    logic [7:0] exp_q [$];
    logic [7:0] pkt [0:79];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        exp_q.delete();
        first_vo_cyc = -1;
        fall_cyc     = -1;
        frame_cycles = 0;
        drop_cnt     = 0;
        hold_pending = 1'b0;
        rdy_phase    = 0;
    endtask

    // Observe the cycle about to be clocked, then advance to 1 ns past the edge
    task automatic tick();
        if (rdy_toggle) begin
            ready_i   = (rdy_phase == 0);
            rdy_phase = (rdy_phase + 1) % 3;
        end else begin
            ready_i = 1'b1;
        end
        if (hold_pending) begin
            check("hold_data", {24'b0, data_o}, {24'b0, held});
            check("hold_valid", {31'b0, valid_o}, 32'd1);
        end
        hold_pending = valid_o && !ready_i;
        held         = data_o;
        if (valid_o && ready_i) got_q.push_back(data_o);
        if (valid_o && first_vo_cyc < 0) first_vo_cyc = cyc;
        if (frame_o) frame_cycles++;
        if (drop_o) drop_cnt++;
        cyc++;
        @(posedge clk_i);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic drive_bits(input int nbits, input logic [7:0] rssi, input logic [6:0] ch);
        logic [7:0] b;
        for (int i = 0; i < nbits; i++) begin
            b         = pkt[i / 8];
            valid_i   = 1'b1;
            serial_i  = b[i % 8];
            rssi_i    = rssi;
            channel_i = ch;
            tick();
        end
    endtask

    task automatic end_packet();
        valid_i  = 1'b0;
        serial_i = 1'b0;
        fall_cyc = cyc;
    endtask

    task automatic compare_frame(input string name);
        int n;
        check({name, "_beats"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_beat%0d", name, i), {24'b0, got_q[i]}, {24'b0, exp_q[i]});
        end
    endtask

    task automatic load_std();
        pkt[0] = 8'hA5;
        pkt[1] = 8'h3C;
        pkt[2] = 8'hFF;
    endtask

    initial begin
        rst_i      = 1'b0;
        serial_i   = 1'b0;
        valid_i    = 1'b0;
        channel_i  = '0;
        rssi_i     = '0;
        ready_i    = 1'b1;
        rdy_toggle = 1'b0;
        clear_mon();
        for (int i = 0; i < 80; i++) pkt[i] = 8'hFF;

        // Reset state
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_valid", {31'b0, valid_o}, 32'd0);
        check("rst_frame", {31'b0, frame_o}, 32'd0);
        check("rst_busy", {31'b0, busy_o}, 32'd0);
        check("rst_drop", {31'b0, drop_o}, 32'd0);
        check("rst_data", {24'b0, data_o}, 32'd0);
        rst_i = 1'b1;
        run(3);

        // 1: basic frame with ready_i held high
        clear_mon();
        load_std();
        drive_bits(24, 8'h5A, 7'd12);
        check("t1_busy_rx", {31'b0, busy_o}, 32'd1);
        end_packet();
        run(15);
        exp_q = '{8'h5A, 8'h0C, 8'h03, 8'hA5, 8'h3C, 8'hFF};
        compare_frame("t1");
        check("t1_latency", first_vo_cyc - fall_cyc, 32'd2);
        check("t1_frame_cycles", frame_cycles, 32'd6);
        check("t1_drop", drop_cnt, 32'd0);
        check("t1_idle", {31'b0, busy_o}, 32'd0);

        // 2: same packet under ready_i pattern 1,0,0
        clear_mon();
        rdy_toggle = 1'b1;
        drive_bits(24, 8'h5A, 7'd12);
        end_packet();
        run(40);
        rdy_toggle = 1'b0;
        exp_q = '{8'h5A, 8'h0C, 8'h03, 8'hA5, 8'h3C, 8'hFF};
        compare_frame("t2");
        check("t2_latency", first_vo_cyc - fall_cyc, 32'd2);

        // 3: truncation, 8*64+5 bits
        clear_mon();
        for (int i = 0; i < 64; i++) pkt[i] = 8'(i * 3 + 1);
        pkt[64] = 8'hFF;
        drive_bits(8 * 64 + 5, 8'h80, 7'd39);
        end_packet();
        run(80);
        exp_q.push_back(8'h80);
        exp_q.push_back(8'h27);
        exp_q.push_back(8'hC0);
        for (int i = 0; i < 64; i++) exp_q.push_back(8'(i * 3 + 1));
        compare_frame("t3");
        check("t3_drop", drop_cnt, 32'd0);

        // 4a: 7-bit packet is dropped
        clear_mon();
        load_std();
        drive_bits(7, 8'h11, 7'd5);
        end_packet();
        tick();
        check("t4a_busy", {31'b0, busy_o}, 32'd0);
        check("t4a_drop_now", {31'b0, drop_o}, 32'd1);
        run(10);
        check("t4a_drops", drop_cnt, 32'd1);
        check("t4a_beats", got_q.size(), 32'd0);

        // 4b: channel 40 is dropped
        clear_mon();
        drive_bits(16, 8'h22, 7'd40);
        end_packet();
        tick();
        check("t4b_busy", {31'b0, busy_o}, 32'd0);
        run(10);
        check("t4b_drops", drop_cnt, 32'd1);
        check("t4b_beats", got_q.size(), 32'd0);

        // 5: second burst arrives during EMIT
        clear_mon();
        load_std();
        drive_bits(24, 8'h5A, 7'd12);
        end_packet();
        run(3);
        drive_bits(16, 8'h33, 7'd7);
        end_packet();
        run(20);
        exp_q = '{8'h5A, 8'h0C, 8'h03, 8'hA5, 8'h3C, 8'hFF};
        compare_frame("t5");
        check("t5_drops", drop_cnt, 32'd1);
        check("t5_idle", {31'b0, busy_o}, 32'd0);

        // 6a: asynchronous reset in the middle of RX
        clear_mon();
        drive_bits(12, 8'h44, 7'd9);
        rst_i = 1'b0;
        #1;
        check("t6a_busy", {31'b0, busy_o}, 32'd0);
        check("t6a_valid", {31'b0, valid_o}, 32'd0);
        check("t6a_drop", {31'b0, drop_o}, 32'd0);
        valid_i = 1'b0;
        #1;
        rst_i = 1'b1;
        run(3);
        pkt[0] = 8'h01;
        pkt[1] = 8'h02;
        drive_bits(16, 8'h11, 7'd3);
        end_packet();
        run(15);
        exp_q = '{8'h11, 8'h03, 8'h02, 8'h01, 8'h02};
        compare_frame("t6a");
        check("t6a_drops", drop_cnt, 32'd0);

        // 6b: asynchronous reset in the middle of EMIT
        clear_mon();
        load_std();
        drive_bits(24, 8'h5A, 7'd12);
        end_packet();
        run(4);
        check("t6b_in_emit", {31'b0, valid_o}, 32'd1);
        rst_i = 1'b0;
        #1;
        check("t6b_valid", {31'b0, valid_o}, 32'd0);
        check("t6b_frame", {31'b0, frame_o}, 32'd0);
        check("t6b_busy", {31'b0, busy_o}, 32'd0);
        check("t6b_data", {24'b0, data_o}, 32'd0);
        #1;
        rst_i = 1'b1;
        run(3);
        clear_mon();
        pkt[0] = 8'h77;
        drive_bits(8, 8'h09, 7'd0);
        end_packet();
        run(12);
        exp_q = '{8'h09, 8'h00, 8'h01, 8'h77};
        compare_frame("t6b");
        check("t6b_drops", drop_cnt, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
